// File: rtl/orange_b_solver.sv
// orange_b_solver
// Scans the 5-bit input space {A,B,C,D,E} (A = bit 4) in ascending order and
// hands out every vector whose Orange_b value equals the requested target,
// honouring a set of pinned input bits. Matches are offered one at a time on
// a valid/ready output.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin a scan (only looked at while idle)
//   target              required function value, latched on accepted start
//   fix_mask, fix_val   pinned input bits/values, latched on accepted start
//   abort               cancel a running scan (no done pulse)
//   out_vec, out_valid  current matching vector and its valid flag
//   out_ready           consumer accepts out_vec
//   busy                high whenever the solver is not idle
//   done                one-cycle pulse when a scan completes
//   match_count         (only with ORANGE_B_SOLVER_COUNT_EN) handshakes in
//                       the most recent scan
//
// Configuration macro: ORANGE_B_SOLVER_COUNT_EN adds the match_count output.
module orange_b_solver (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       target,
    input  logic [4:0] fix_mask,
    input  logic [4:0] fix_val,
    input  logic       abort,
    output logic [4:0] out_vec,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
`ifdef ORANGE_B_SOLVER_COUNT_EN
    output logic [5:0] match_count,
`endif
    output logic       done
);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

    state_t     state_q, state_d;
    logic [4:0] index_q, index_d;
    logic       tgt_q, tgt_d;
    logic [4:0] mask_q, mask_d;
    logic [4:0] val_q, val_d;
    logic [4:0] out_vec_q, out_vec_d;
    logic       out_valid_q, out_valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [5:0] cnt_q, cnt_d;

    function automatic logic orange_b(input logic [4:0] v);
        logic a, b, c, d, e;
        {a, b, c, d, e} = v;
        return (a & b & c) | (a & b & d) | (a & b & e) | (a & c & d) |
               (a & c & e) | ~(a | d | e) | (~b & ~c & d) | (~b & ~c & e) |
               (~b & ~d & ~e) | (~c & ~d & ~e);
    endfunction

    logic eligible;
    assign eligible = ((index_q & mask_q) == (val_q & mask_q)) &&
                      (orange_b(index_q) == tgt_q);

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        tgt_d     = tgt_q;
        mask_d    = mask_q;
        val_d     = val_q;
        out_vec_d = out_vec_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    index_d = '0;
                    tgt_d   = target;
                    mask_d  = fix_mask;
                    val_d   = fix_val;
                    cnt_d   = '0;
                end
            end
            SCAN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (eligible) begin
                    state_d   = EMIT;
                    out_vec_d = index_q;
                end else if (index_q == 5'd31) begin
                    state_d = DONE;
                end else begin
                    index_d = index_q + 5'd1;
                end
            end
            EMIT: begin
                // abort wins over a simultaneous handshake
                if (abort) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    cnt_d = cnt_q + 6'd1;
                    if (out_vec_q == 5'd31) begin
                        state_d = DONE;
                    end else begin
                        state_d = SCAN;
                        index_d = out_vec_q + 5'd1;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Status outputs are registered images of the next state.
        out_valid_d = (state_d == EMIT);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            index_q     <= '0;
            tgt_q       <= 1'b0;
            mask_q      <= '0;
            val_q       <= '0;
            out_vec_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            tgt_q       <= tgt_d;
            mask_q      <= mask_d;
            val_q       <= val_d;
            out_vec_q   <= out_vec_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_vec   = out_vec_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef ORANGE_B_SOLVER_COUNT_EN
    assign match_count = cnt_q;
`else
    logic unused_cnt;
    assign unused_cnt = ^cnt_q;
`endif

endmodule
